// File: rtl/lct_l1a_window_match_pkg.sv
// Shared L1A-match definitions: FSM state encoding and the window-length width, which also
// sets the address width of the upstream 16-deep LCT delay line.
package lct_l1a_window_match_pkg;

  localparam int unsigned WinLenW = 4;

  typedef enum logic [0:0] {
    StIdle = 1'b0,
    StOpen = 1'b1
  } state_e;

endpackage

// File: rtl/lct_l1a_window_match_sat_counter.sv
// Saturating event counter with synchronous clear; clear wins over increment, CE freezes it.
module sat_counter #(
  parameter int unsigned W = 12
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic         CE,
  input  logic         CLR,
  input  logic         INC,
  output logic [W-1:0] Q
);

  logic [W-1:0] q_q;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      q_q <= '0;
    end else if (CE) begin
      if (CLR) begin
        q_q <= '0;
      end else if (INC && (q_q != {W{1'b1}})) begin
        q_q <= q_q + W'(1);
      end
    end
  end

  assign Q = q_q;

endmodule

// File: rtl/lct_l1a_window_match.sv
// Opens a programmable coincidence window per delayed LCT and classifies each L1A / window
// outcome into registered one-clock pulses plus saturating status counters.
module lct_l1a_window_match
  import lct_l1a_window_match_pkg::*;
#(
  parameter int unsigned CNT_W = 12
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               CE,
  input  logic               LCT_DLY,
  input  logic               L1A,
  input  logic [WinLenW-1:0] WIN_LEN,
  input  logic               CNT_CLR,
  output logic               WIN_OPEN,
  output logic               L1A_MATCH,
  output logic               L1A_NOMATCH,
  output logic               LCT_MISS,
  output logic               LCT_OVL,
  output logic [CNT_W-1:0]   MATCH_CNT,
  output logic [CNT_W-1:0]   NOMATCH_CNT,
  output logic [CNT_W-1:0]   MISS_CNT
);

  state_e             state_q, state_d;
  logic [WinLenW-1:0] wcnt_q, wcnt_d;
  logic               match_q, match_d;
  logic               nomatch_q, nomatch_d;
  logic               miss_q, miss_d;
  logic               ovl_q, ovl_d;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q   <= StIdle;
      wcnt_q    <= '0;
      match_q   <= 1'b0;
      nomatch_q <= 1'b0;
      miss_q    <= 1'b0;
      ovl_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      wcnt_q    <= wcnt_d;
      match_q   <= match_d;
      nomatch_q <= nomatch_d;
      miss_q    <= miss_d;
      ovl_q     <= ovl_d;
    end
  end

  // Pulses default to 0 every clock, so a frozen (CE=0) cycle registers all-zero pulses.
  always_comb begin
    state_d   = state_q;
    wcnt_d    = wcnt_q;
    match_d   = 1'b0;
    nomatch_d = 1'b0;
    miss_d    = 1'b0;
    ovl_d     = 1'b0;
    if (CE) begin
      unique case (state_q)
        StIdle: begin
          if (LCT_DLY) begin
            if (L1A) begin
              match_d = 1'b1;
            end else if (WIN_LEN == '0) begin
              miss_d = 1'b1;
            end else begin
              wcnt_d  = WIN_LEN;
              state_d = StOpen;
            end
          end else if (L1A) begin
            nomatch_d = 1'b1;
          end
        end
        StOpen: begin
          // A second LCT never restarts or extends the running window.
          ovl_d = LCT_DLY;
          if (L1A) begin
            match_d = 1'b1;
            state_d = StIdle;
          end else if (wcnt_q == WinLenW'(1)) begin
            miss_d  = 1'b1;
            state_d = StIdle;
          end else begin
            wcnt_d = wcnt_q - WinLenW'(1);
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  assign WIN_OPEN    = (state_q == StOpen);
  assign L1A_MATCH   = match_q;
  assign L1A_NOMATCH = nomatch_q;
  assign LCT_MISS    = miss_q;
  assign LCT_OVL     = ovl_q;

  // Counters take the next-state pulse so they step on the same edge the pulse registers.
  sat_counter #(.W(CNT_W)) u_match_cnt (
    .CLK   (CLK),
    .RST_N (RST_N),
    .CE    (CE),
    .CLR   (CNT_CLR),
    .INC   (match_d),
    .Q     (MATCH_CNT)
  );

  sat_counter #(.W(CNT_W)) u_nomatch_cnt (
    .CLK   (CLK),
    .RST_N (RST_N),
    .CE    (CE),
    .CLR   (CNT_CLR),
    .INC   (nomatch_d),
    .Q     (NOMATCH_CNT)
  );

  sat_counter #(.W(CNT_W)) u_miss_cnt (
    .CLK   (CLK),
    .RST_N (RST_N),
    .CE    (CE),
    .CLR   (CNT_CLR),
    .INC   (miss_d),
    .Q     (MISS_CNT)
  );

endmodule

// File: tb/tb_lct_l1a_window_match.sv
// Directed and randomized bench for lct_l1a_window_match against a deadline-based window model.
module tb_lct_l1a_window_match;

  localparam int CW     = 3;
  localparam int CntMax = (1 << CW) - 1;

  logic          CLK = 1'b0;
  logic          RST_N, CE, LCT_DLY, L1A, CNT_CLR;
  logic [3:0]    WIN_LEN;
  logic          WIN_OPEN, L1A_MATCH, L1A_NOMATCH, LCT_MISS, LCT_OVL;
  logic [CW-1:0] MATCH_CNT, NOMATCH_CNT, MISS_CNT;

  lct_l1a_window_match #(.CNT_W(CW)) dut (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .CE          (CE),
    .LCT_DLY     (LCT_DLY),
    .L1A         (L1A),
    .WIN_LEN     (WIN_LEN),
    .CNT_CLR     (CNT_CLR),
    .WIN_OPEN    (WIN_OPEN),
    .L1A_MATCH   (L1A_MATCH),
    .L1A_NOMATCH (L1A_NOMATCH),
    .LCT_MISS    (LCT_MISS),
    .LCT_OVL     (LCT_OVL),
    .MATCH_CNT   (MATCH_CNT),
    .NOMATCH_CNT (NOMATCH_CNT),
    .MISS_CNT    (MISS_CNT)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int passes = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Model: a window is a deadline on the enabled-cycle index; L1A accepted at t0..t0+wl.
  int ecnt = 0, t0 = 0, wl = 0;
  bit mopen = 0, mvalid = 0;
  bit e_win, e_match, e_nom, e_miss, e_ovl;
  int e_mc, e_nc, e_xc;

  function automatic int sat_inc(input int v);
    return (v >= CntMax) ? CntMax : v + 1;
  endfunction

  always @(posedge CLK) begin
    if (!RST_N) begin
      mvalid = 1; mopen = 0; e_win = 0;
      e_match = 0; e_nom = 0; e_miss = 0; e_ovl = 0;
      e_mc = 0; e_nc = 0; e_xc = 0;
    end else begin
      e_match = 0; e_nom = 0; e_miss = 0; e_ovl = 0;
      if (CE) begin
        ecnt++;
        if (mopen) begin
          if (LCT_DLY) e_ovl = 1;
          if (L1A) begin
            e_match = 1; mopen = 0;
          end else if (ecnt == t0 + wl) begin
            e_miss = 1; mopen = 0;
          end
        end else if (LCT_DLY) begin
          if (L1A) e_match = 1;
          else if (WIN_LEN == 0) e_miss = 1;
          else begin
            mopen = 1; t0 = ecnt; wl = int'(WIN_LEN);
          end
        end else if (L1A) begin
          e_nom = 1;
        end
        if (CNT_CLR) begin
          e_mc = 0; e_nc = 0; e_xc = 0;
        end else begin
          if (e_match) e_mc = sat_inc(e_mc);
          if (e_nom)   e_nc = sat_inc(e_nc);
          if (e_miss)  e_xc = sat_inc(e_xc);
        end
        e_win = mopen;
      end
    end
  end

  always @(negedge CLK) begin
    if (mvalid) begin
      chk("pulses{match,nomatch,miss,ovl}", int'({L1A_MATCH, L1A_NOMATCH, LCT_MISS, LCT_OVL}),
          int'({e_match, e_nom, e_miss, e_ovl}));
      chk("win_open", int'(WIN_OPEN), int'(e_win));
      chk("match_cnt", int'(MATCH_CNT), e_mc);
      chk("nomatch_cnt", int'(NOMATCH_CNT), e_nc);
      chk("miss_cnt", int'(MISS_CNT), e_xc);
    end
  end

  // Apply inputs for one cycle; returns #1 after the edge that registered them.
  task automatic drive(input bit lct, input bit l1a);
    LCT_DLY = lct;
    L1A     = l1a;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RST_N = 0; CE = 1; LCT_DLY = 0; L1A = 0; CNT_CLR = 0; WIN_LEN = 4'd3;
    repeat (2) @(posedge CLK);
    #1;
    chk("reset win_open", int'(WIN_OPEN), 0);
    chk("reset match_cnt", int'(MATCH_CNT), 0);
    RST_N = 1;

    // WIN_LEN=3: L1A on the last accepted cycle matches.
    drive(1, 0);
    chk("d1 win rises", int'(WIN_OPEN), 1);
    drive(0, 0); drive(0, 0);
    drive(0, 1);
    chk("d1 match", int'(L1A_MATCH), 1);
    chk("d1 match_cnt", int'(MATCH_CNT), 1);
    chk("d1 win falls", int'(WIN_OPEN), 0);

    // No L1A: miss, then the late L1A is a no-match.
    drive(1, 0); drive(0, 0); drive(0, 0); drive(0, 0);
    chk("d2 miss", int'(LCT_MISS), 1);
    chk("d2 miss_cnt", int'(MISS_CNT), 1);
    drive(0, 1);
    chk("d2 nomatch", int'(L1A_NOMATCH), 1);

    // WIN_LEN=0: same-cycle only.
    WIN_LEN = 4'd0;
    drive(1, 1);
    chk("d3 match", int'(L1A_MATCH), 1);
    chk("d3 match_cnt", int'(MATCH_CNT), 2);
    drive(1, 0);
    chk("d3 miss", int'(LCT_MISS), 1);
    chk("d3 win", int'(WIN_OPEN), 0);

    // Overlapping LCT is dropped; a single match, no miss afterwards.
    WIN_LEN = 4'd5;
    drive(1, 0); drive(0, 0);
    drive(1, 0);
    chk("d4 ovl", int'(LCT_OVL), 1);
    drive(0, 0);
    drive(0, 1);
    chk("d4 match", int'(L1A_MATCH), 1);
    repeat (6) drive(0, 0);
    chk("d4 no extra miss", int'(MISS_CNT), 2);

    // CE low mid-window stretches it in time but not in enabled cycles.
    WIN_LEN = 4'd2;
    drive(1, 0);
    CE = 0;
    repeat (4) begin
      drive(1, 1);
      chk("d5 frozen match", int'(L1A_MATCH), 0);
      chk("d5 frozen win", int'(WIN_OPEN), 1);
    end
    CE = 1;
    drive(0, 0);
    drive(0, 0);
    chk("d5 miss", int'(LCT_MISS), 1);

    // Reset mid-window discards it silently.
    drive(1, 0); drive(0, 0);
    RST_N = 0;
    drive(0, 0);
    chk("d6 win", int'(WIN_OPEN), 0);
    chk("d6 miss_cnt", int'(MISS_CNT), 0);
    RST_N = 1;
    drive(0, 0);
    chk("d6 no miss", int'(LCT_MISS), 0);

    // Saturation and clear-over-increment.
    repeat (CntMax + 2) drive(0, 1);
    chk("d7 nomatch sat", int'(NOMATCH_CNT), CntMax);
    CNT_CLR = 1;
    drive(0, 1);
    CNT_CLR = 0;
    chk("d7 clr pulse", int'(L1A_NOMATCH), 1);
    chk("d7 clr cnt", int'(NOMATCH_CNT), 0);

    // Randomized traffic checked every cycle by the model.
    for (int i = 0; i < 4000; i++) begin
      RST_N   = ($urandom_range(0, 599) != 0);
      CE      = ($urandom_range(0, 7) != 0);
      CNT_CLR = ($urandom_range(0, 199) == 0);
      WIN_LEN = 4'($urandom_range(0, 15));
      drive(($urandom_range(0, 5) == 0), ($urandom_range(0, 4) == 0));
    end

    RST_N = 1; CE = 1; CNT_CLR = 0;
    drive(0, 0);
    @(negedge CLK);
    #1;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
